fib_timer_engine: RTL and testbench
===================================

# fib_timer_engine

Parametrised sequence engine generating either Fibonacci terms or an up-count timer at a programmable step rate. A prog-latched step limit ends each run, with stop/restart control, overflow detection, and a parity bit on the current value. It sits behind the board-level top, which debounces start_f/start_t/stop_f_t/update and drives value onto the LEDs and 7-segment display.

## Interface
- WIDTH, 16, width of value and internal sum registers
- PROG_W, 3, width of prog
- TICK_DIV, 4, clock cycles per sequence step (≥1)
- LIMIT_SHIFT, 2, step limit = (prog_reg+1) << LIMIT_SHIFT; requires WIDTH ≥ PROG_W+LIMIT_SHIFT+1

- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low; sampled on clock rising edge
- start_f  in  1  one-cycle pulse, start Fibonacci run
- start_t  in  1  one-cycle pulse, start timer run
- stop_f_t  in  1  one-cycle pulse, stop current run
- update  in  1  one-cycle pulse, latch prog into prog_reg
- prog  in  PROG_W  step-limit selector
- value  out  WIDTH  current sequence value (registered)
- valid  out  1  one-cycle pulse on each value update
- busy  out  1  run in progress
- mode_f  out  1  1 = last/current run is Fibonacci, 0 = timer
- done  out  1  run ended by reaching limit or overflow
- overflow  out  1  Fibonacci run ended on carry-out
- parity  out  1  XOR of all value bits (combinational from value register)

## Operation
- States: IDLE, RUN_F, RUN_T, HOLD.
- IDLE/HOLD:
  - update → prog_reg ← prog.
  - start_f → RUN_F; else start_t → RUN_T.
  - start_f has priority over start_t.
  - stop_f_t is ignored.
  - start and update in the same cycle: prog_reg is updated and the new run uses the new limit.
- Start accepted:
  - Clears value, step_cnt, prescaler, done and overflow.
  - Sets busy.
  - mode_f ← 1 for start_f, 0 for start_t.
  - Fibonacci aux register a ← 1.
- RUN_*:
  - update, start_f and start_t are ignored.
  - Prescaler counts 0..TICK_DIV-1; a step fires on the edge where the prescaler equals TICK_DIV-1.
- Fibonacci step:
  - Sum = value + a, computed in WIDTH+1 bits.
  - No carry: value ← sum, a ← value, step_cnt+1, valid pulse.
  - Carry-out: value and a hold, no valid, overflow ← 1, done ← 1, go to HOLD.
  - Output sequence: 1,1,2,3,5,8,…
- Timer step: value ← value+1, step_cnt+1, valid pulse.
- Limit: on the step where step_cnt+1 equals the limit → done ← 1, busy ← 0, go to HOLD, same edge as the last value update.
- stop_f_t in RUN_*: go to HOLD, busy ← 0, value held, done stays 0. If it coincides with a step edge, stop wins and the step is discarded.
- HOLD: value, done, overflow and mode_f are held until the next start or reset.
- reset low (any state, including mid-run):
  - State IDLE, prog_reg 0, prescaler/step_cnt/a cleared.
  - All outputs 0.

## Timing
- Reset values: value=0, valid=0, busy=0, mode_f=0, done=0, overflow=0, parity=0.
- Start pulse sampled at edge k:
  - busy=1 and value=0 from edge k.
  - Step n updates value at edge k+n·TICK_DIV.
- valid is high for exactly the one cycle following each step edge.
- Run ends at edge k+L·TICK_DIV, where L is the limit; busy falls and done rises on that edge.
- Overflow ends the run at the overflowing step's edge; busy falls and overflow/done rise on that edge.
- Control pulses act on the edge where they are sampled, with no extra latency.

## Test plan
Defaults WIDTH=8, TICK_DIV=4, LIMIT_SHIFT=2.
1. Reset low 3 cycles, then high → all outputs 0, state IDLE. Start_t → run ends with value=4 (prog_reg=0 gives limit 4).
2. update with prog=3, then start_t at edge k → value 1..16 at edges k+4..k+64. Exactly 16 valid pulses. done=1, busy=0 at k+64; value=16, parity=1.
3. prog=7, start_f → values 1,1,2,3,5,8,13,21,34,55,89,144,233. At k+56, overflow=1 and done=1; value stays 233 (parity=1); no 14th valid.
4. prog=3, start_f at k, stop_f_t at k+10 → value=1 (two steps), busy=0, done=0. Then start_t → value clears to 0, mode_f=0, count restarts.
5. During RUN_T: update with prog=0 → prog_reg unchanged, run still ends at 16. start_f and start_t in the same cycle from IDLE → mode_f=1.
6. reset low mid-Fibonacci run → next edge: value=0, busy=0, prog_reg=0. stop_f_t on a step edge → value not updated.

Source files
------------

// File: rtl/fib_timer_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : fib_timer_engine_if
// Description : Control/status bundle for fib_timer_engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface fib_timer_engine_if #(
  parameter int WIDTH  = 16,
  parameter int PROG_W = 3
);
  logic              start_f;
  logic              start_t;
  logic              stop_f_t;
  logic              update;
  logic [PROG_W-1:0] prog;
  logic [WIDTH-1:0]  value;
  logic              valid;
  logic              busy;
  logic              mode_f;
  logic              done;
  logic              overflow;
  logic              parity;

  modport master (
    output start_f, start_t, stop_f_t, update, prog,
    input  value, valid, busy, mode_f, done, overflow, parity
  );

  modport slave (
    input  start_f, start_t, stop_f_t, update, prog,
    output value, valid, busy, mode_f, done, overflow, parity
  );
endinterface
`default_nettype wire

// File: rtl/fib_timer_engine.sv
`default_nettype none
// ============================================================================
// Module      : fib_timer_engine
// Description : Fibonacci / up-count timer sequence engine with programmable
//               step limit, stop/restart control and overflow detection.
// Revision    : 1.0 - initial release
// ============================================================================
module fib_timer_engine #(
  parameter int WIDTH       = 16,
  parameter int PROG_W      = 3,
  parameter int TICK_DIV    = 4,
  parameter int LIMIT_SHIFT = 2
) (
  input  logic                clock,
  input  logic                reset,
  fib_timer_engine_if.slave   bus
);
  localparam int                 PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] TICK_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [PRESC_W-1:0] ONE_P     = PRESC_W'(1);
  localparam logic [WIDTH-1:0]   ONE_W     = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN_F = 2'd1,
    RUN_T = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [PROG_W-1:0]  r_prog, w_prog_nxt;
  logic [WIDTH-1:0]   r_value, w_value_nxt;
  logic [WIDTH-1:0]   r_aux, w_aux_nxt;
  logic [WIDTH-1:0]   r_step, w_step_nxt;
  logic [PRESC_W-1:0] r_presc, w_presc_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_mode_f, w_mode_f_nxt;
  logic               r_done, w_done_nxt;
  logic               r_ovf, w_ovf_nxt;

  logic [WIDTH-1:0]   w_limit;
  logic [WIDTH-1:0]   w_step_inc;
  logic [WIDTH:0]     w_sum;
  logic               w_tick;

  assign w_limit    = ({{(WIDTH-PROG_W){1'b0}}, r_prog} + ONE_W) << LIMIT_SHIFT;
  assign w_step_inc = r_step + ONE_W;
  // One extra bit so the carry-out of the Fibonacci add is visible
  assign w_sum      = {1'b0, r_value} + {1'b0, r_aux};
  assign w_tick     = (r_presc == TICK_LAST);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_prog_nxt   = r_prog;
    w_value_nxt  = r_value;
    w_aux_nxt    = r_aux;
    w_step_nxt   = r_step;
    w_presc_nxt  = r_presc;
    w_valid_nxt  = 1'b0;
    w_busy_nxt   = r_busy;
    w_mode_f_nxt = r_mode_f;
    w_done_nxt   = r_done;
    w_ovf_nxt    = r_ovf;

    case (r_state)
      IDLE, HOLD: begin
        if (bus.update) begin
          w_prog_nxt = bus.prog;
        end
        if (bus.start_f || bus.start_t) begin
          w_value_nxt  = '0;
          w_aux_nxt    = ONE_W;
          w_step_nxt   = '0;
          w_presc_nxt  = '0;
          w_done_nxt   = 1'b0;
          w_ovf_nxt    = 1'b0;
          w_busy_nxt   = 1'b1;
          w_mode_f_nxt = bus.start_f;
          w_state_nxt  = bus.start_f ? RUN_F : RUN_T;
        end
      end

      RUN_F, RUN_T: begin
        if (bus.stop_f_t) begin
          // Stop beats a coincident step: the pending step is dropped
          w_busy_nxt  = 1'b0;
          w_state_nxt = HOLD;
        end else if (w_tick) begin
          w_presc_nxt = '0;
          if ((r_state == RUN_F) && w_sum[WIDTH]) begin
            w_ovf_nxt   = 1'b1;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = HOLD;
          end else begin
            if (r_state == RUN_F) begin
              w_value_nxt = w_sum[WIDTH-1:0];
              w_aux_nxt   = r_value;
            end else begin
              w_value_nxt = r_value + ONE_W;
            end
            w_step_nxt  = w_step_inc;
            w_valid_nxt = 1'b1;
            if (w_step_inc == w_limit) begin
              w_done_nxt  = 1'b1;
              w_busy_nxt  = 1'b0;
              w_state_nxt = HOLD;
            end
          end
        end else begin
          w_presc_nxt = r_presc + ONE_P;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_prog   <= '0;
      r_value  <= '0;
      r_aux    <= '0;
      r_step   <= '0;
      r_presc  <= '0;
      r_valid  <= 1'b0;
      r_busy   <= 1'b0;
      r_mode_f <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_prog   <= w_prog_nxt;
      r_value  <= w_value_nxt;
      r_aux    <= w_aux_nxt;
      r_step   <= w_step_nxt;
      r_presc  <= w_presc_nxt;
      r_valid  <= w_valid_nxt;
      r_busy   <= w_busy_nxt;
      r_mode_f <= w_mode_f_nxt;
      r_done   <= w_done_nxt;
      r_ovf    <= w_ovf_nxt;
    end
  end

  assign bus.value    = r_value;
  assign bus.valid    = r_valid;
  assign bus.busy     = r_busy;
  assign bus.mode_f   = r_mode_f;
  assign bus.done     = r_done;
  assign bus.overflow = r_ovf;
  assign bus.parity   = ^r_value;

endmodule
`default_nettype wire

// File: tb/tb_fib_timer_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_fib_timer_engine
// Description : Self-checking bench for fib_timer_engine (WIDTH=8, TICK_DIV=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fib_timer_engine;
  localparam int WIDTH       = 8;
  localparam int PROG_W      = 3;
  localparam int TICK_DIV    = 4;
  localparam int LIMIT_SHIFT = 2;

  logic clock;
  logic rst_n;
  int   cyc;
  int   n_vec;
  int   n_miss;

  fib_timer_engine_if #(.WIDTH(WIDTH), .PROG_W(PROG_W)) bus ();

  fib_timer_engine #(
    .WIDTH(WIDTH), .PROG_W(PROG_W), .TICK_DIV(TICK_DIV), .LIMIT_SHIFT(LIMIT_SHIFT)
  ) dut (
    .clock (clock),
    .reset (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit is_f;
    int prog;
    bit upd;
    bit mid_upd;
    int exp_val;
    bit exp_ovf;
    bit exp_par;
  } vec_t;

  typedef struct {
    int v;
    int c;
  } exp_t;

  vec_t vecs [7];
  exp_t q [$];
  exp_t mon_e;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every valid pulse must match the next expected step value and cycle
  always @(negedge clock) begin
    if (rst_n && bus.valid) begin
      if (q.size() == 0) begin
        chk("extra_valid", 1, 0);
      end else begin
        mon_e = q.pop_front();
        chk("step_value", int'(bus.value), mon_e.v);
        chk("step_cycle", cyc, mon_e.c);
      end
    end
  end

  task automatic set_ctrl(input bit sf, input bit st, input bit sp, input bit up, input int pr);
    bus.start_f  = sf;
    bus.start_t  = st;
    bus.stop_f_t = sp;
    bus.update   = up;
    bus.prog     = PROG_W'(pr);
  endtask

  // Drive a one-cycle pulse so that it is sampled on posedge number e
  task automatic pulse_at(input int e, input bit sf, input bit st, input bit sp,
                          input bit up, input int pr);
    while (cyc < e - 1) @(negedge clock);
    set_ctrl(sf, st, sp, up, pr);
    @(negedge clock);
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, pr);
  endtask

  task automatic run_vec(input vec_t v);
    int L, nv, a, val, s, k, end_steps, guard;
    bit ovf;
    L   = (v.prog + 1) << LIMIT_SHIFT;
    k   = cyc + 1;
    ovf = 1'b0;
    nv  = 0;
    a   = 1;
    val = 0;
    for (int n = 1; n <= L; n++) begin
      if (v.is_f) begin
        s = val + a;
        if (s > 255) begin
          ovf = 1'b1;
          break;
        end
        a   = val;
        val = s;
      end else begin
        val = n;
      end
      q.push_back('{val, k + TICK_DIV * n});
      nv = n;
    end
    end_steps = ovf ? nv + 1 : L;

    set_ctrl(v.is_f, !v.is_f, 1'b0, v.upd, v.prog);
    @(negedge clock);
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, v.prog);
    chk("start_busy", int'(bus.busy), 1);
    chk("start_value", int'(bus.value), 0);
    chk("start_mode_f", int'(bus.mode_f), int'(v.is_f));
    chk("start_done", int'(bus.done), 0);

    if (v.mid_upd) pulse_at(k + 6, 1'b0, 1'b0, 1'b0, 1'b1, 0);

    guard = 0;
    while (bus.busy && guard < 400) begin
      @(negedge clock);
      guard++;
    end
    if (bus.busy) begin
      chk("run_timeout", 1, 0);
      q.delete();
    end
    chk("end_cycle", cyc - k, TICK_DIV * end_steps);
    chk("end_value", int'(bus.value), v.exp_val);
    chk("end_done", int'(bus.done), 1);
    chk("end_overflow", int'(bus.overflow), int'(v.exp_ovf));
    chk("end_parity", int'(bus.parity), int'(v.exp_par));
    chk("end_mode_f", int'(bus.mode_f), int'(v.is_f));
    @(negedge clock);
    chk("leftover_steps", q.size(), 0);
    chk("hold_value", int'(bus.value), v.exp_val);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int k;
    n_vec  = 0;
    n_miss = 0;
    //            is_f prog upd mid  val  ovf par
    vecs[0] = '{1'b0, 0, 1'b0, 1'b0,   4, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 3, 1'b1, 1'b0,  16, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 7, 1'b1, 1'b0, 233, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1, 1'b1, 1'b0,  21, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 5, 1'b1, 1'b0,  24, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 2, 1'b1, 1'b0, 144, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 3, 1'b1, 1'b1,  16, 1'b0, 1'b1};

    rst_n = 1'b0;
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 0);
    repeat (3) @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    chk("rst_value", int'(bus.value), 0);
    chk("rst_valid", int'(bus.valid), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_mode_f", int'(bus.mode_f), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_overflow", int'(bus.overflow), 0);
    chk("rst_parity", int'(bus.parity), 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Stop mid-run after two Fibonacci steps, then restart as a timer
    k = cyc + 1;
    set_ctrl(1'b1, 1'b0, 1'b0, 1'b1, 3);
    q.push_back('{1, k + 4});
    q.push_back('{1, k + 8});
    @(negedge clock);
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 3);
    pulse_at(k + 10, 1'b0, 1'b0, 1'b1, 1'b0, 3);
    chk("stop_value", int'(bus.value), 1);
    chk("stop_busy", int'(bus.busy), 0);
    chk("stop_done", int'(bus.done), 0);
    repeat (3) @(negedge clock);
    chk("stop_hold_value", int'(bus.value), 1);
    chk("stop_leftover", q.size(), 0);

    k = cyc + 1;
    set_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 3);
    q.push_back('{1, k + 4});
    @(negedge clock);
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 3);
    chk("restart_value", int'(bus.value), 0);
    chk("restart_mode_f", int'(bus.mode_f), 0);
    chk("restart_busy", int'(bus.busy), 1);
    while (cyc < k + 5) @(negedge clock);
    chk("restart_step1", int'(bus.value), 1);
    pulse_at(k + 6, 1'b0, 1'b0, 1'b1, 1'b0, 3);

    // Stop sampled on the same edge as step 2: the step must be discarded
    k = cyc + 1;
    set_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 3);
    q.push_back('{1, k + 4});
    @(negedge clock);
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 3);
    pulse_at(k + 8, 1'b0, 1'b0, 1'b1, 1'b0, 3);
    chk("stop_on_step_value", int'(bus.value), 1);
    chk("stop_on_step_busy", int'(bus.busy), 0);
    @(negedge clock);
    chk("stop_on_step_leftover", q.size(), 0);
    chk("stop_on_step_hold", int'(bus.value), 1);

    // Both starts together: Fibonacci wins
    k = cyc + 1;
    set_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 3);
    @(negedge clock);
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 3);
    chk("both_start_mode_f", int'(bus.mode_f), 1);
    chk("both_start_busy", int'(bus.busy), 1);
    pulse_at(k + 2, 1'b0, 1'b0, 1'b1, 1'b0, 3);

    // Reset in the middle of a Fibonacci run
    k = cyc + 1;
    set_ctrl(1'b1, 1'b0, 1'b0, 1'b1, 3);
    q.push_back('{1, k + 4});
    @(negedge clock);
    set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 3);
    while (cyc < k + 5) @(negedge clock);
    chk("pre_reset_value", int'(bus.value), 1);
    q.delete();
    rst_n = 1'b0;
    @(negedge clock);
    chk("mid_reset_value", int'(bus.value), 0);
    chk("mid_reset_busy", int'(bus.busy), 0);
    chk("mid_reset_mode_f", int'(bus.mode_f), 0);
    rst_n = 1'b1;
    @(negedge clock);
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
`default_nettype wire
